// File: rtl/event_scheduler_pkg.sv
// Shared types and defaults for the event generator / scheduler / pulse pattern chain.
package event_pkg;

   localparam int COORD_W         = 10;
   localparam int DEFAULT_PERIOD  = 100;
   localparam int DEFAULT_LATENCY = 2;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      GAP
   } sched_state_t;

   typedef struct packed {
      logic [COORD_W-1:0] x1;
      logic [COORD_W-1:0] x2;
      logic [COORD_W-1:0] y1;
      logic [COORD_W-1:0] y2;
   } coord_t;

endpackage

// File: rtl/event_scheduler_if.sv
// Valid/ready event hand-off from the scheduler to the pulse pattern generator.
interface event_scheduler_if;
   import event_pkg::*;

   logic               evt_valid_o;
   logic               evt_ready_i;
   logic [COORD_W-1:0] x1_o;
   logic [COORD_W-1:0] x2_o;
   logic [COORD_W-1:0] y1_o;
   logic [COORD_W-1:0] y2_o;

   modport master (
      output evt_valid_o, x1_o, x2_o, y1_o, y2_o,
      input  evt_ready_i
   );

   modport slave (
      input  evt_valid_o, x1_o, x2_o, y1_o, y2_o,
      output evt_ready_i
   );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             inc,
   input  logic             clear,
   output logic [WIDTH-1:0] count
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + ONE;
      end
   end

endmodule

// File: rtl/event_scheduler.sv
// Slot-based sequencer: pulses the event generator once per slot, captures its result
// after a fixed latency and hands accepted events downstream over valid/ready.
module event_scheduler
   import event_pkg::*;
#(
   parameter int PERIOD_CYCLES  = DEFAULT_PERIOD,
   parameter int RESULT_LATENCY = DEFAULT_LATENCY,
   parameter int CNT_W          = 32
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               enable_i,
   input  logic [15:0]        burst_len_i,
   output logic               start_o,
   input  logic               gen_valid_i,
   input  logic [COORD_W-1:0] x1_i,
   input  logic [COORD_W-1:0] x2_i,
   input  logic [COORD_W-1:0] y1_i,
   input  logic [COORD_W-1:0] y2_i,
   event_scheduler_if.master  evt,
   output logic               busy_o,
   output logic               done_o,
   output logic [CNT_W-1:0]   accepted_cnt_o,
   output logic [CNT_W-1:0]   rejected_cnt_o,
   output logic [CNT_W-1:0]   overrun_cnt_o
);

   localparam int TIMER_W = $clog2(PERIOD_CYCLES);
   localparam int WAIT_W  = (RESULT_LATENCY > 1) ? $clog2(RESULT_LATENCY) : 1;
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(PERIOD_CYCLES - 1);
   localparam logic [WAIT_W-1:0]  WAIT_INIT  = WAIT_W'(RESULT_LATENCY - 1);

   if ((PERIOD_CYCLES < RESULT_LATENCY + 2) || (RESULT_LATENCY < 1)) begin : g_bad_params
      $error("event_scheduler: PERIOD_CYCLES must be >= RESULT_LATENCY + 2 and RESULT_LATENCY >= 1");
   end

   sched_state_t       state;
   logic [TIMER_W-1:0] timer;
   logic [WAIT_W-1:0]  wait_cnt;
   logic [15:0]        burst_len;
   logic [15:0]        burst_cnt;
   logic               burst_hold;
   logic               done_armed;
   logic               evt_valid;
   coord_t             coord;

   logic handshake;
   logic sample;
   logic accept;
   logic reject;
   logic overrun;
   logic valid_next;
   logic burst_hit;
   logic final_accept;

   assign handshake    = evt_valid & evt.evt_ready_i;
   assign sample       = (state == WAIT) && (wait_cnt == '0);
   assign accept       = sample & gen_valid_i;
   assign reject       = sample & ~gen_valid_i;
   assign overrun      = (state == ISSUE) && !start_o;
   // Loads never coincide with a handshake, so this is the exact next value of evt_valid.
   assign valid_next   = accept | (evt_valid & ~evt.evt_ready_i);
   assign burst_hit    = (burst_len != 16'd0) && (burst_cnt == burst_len);
   assign final_accept = accept && (burst_len != 16'd0) && ((burst_cnt + 16'd1) == burst_len);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         timer      <= '0;
         wait_cnt   <= '0;
         burst_len  <= '0;
         burst_cnt  <= '0;
         burst_hold <= 1'b0;
         done_armed <= 1'b0;
         evt_valid  <= 1'b0;
         coord      <= '0;
         start_o    <= 1'b0;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
      end else begin
         start_o <= 1'b0;
         done_o  <= 1'b0;
         timer   <= ((state == IDLE) || (timer == TIMER_LAST)) ? '0 : timer + TIMER_W'(1);

         if (handshake) begin
            evt_valid <= 1'b0;
         end
         if (accept) begin
            evt_valid <= 1'b1;
            coord     <= '{x1: x1_i, x2: x2_i, y1: y1_i, y2: y2_i};
         end

         // The burst is only complete once its last event has actually left.
         if (done_armed && !valid_next) begin
            done_o     <= 1'b1;
            done_armed <= 1'b0;
         end
         if (final_accept) begin
            done_armed <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (!enable_i) begin
                  burst_hold <= 1'b0;
               end
               if (enable_i && !burst_hold) begin
                  burst_len <= burst_len_i;
                  burst_cnt <= '0;
                  state     <= ISSUE;
                  start_o   <= !valid_next;
                  busy_o    <= 1'b1;
               end else begin
                  busy_o <= valid_next;
               end
            end
            ISSUE: begin
               state    <= start_o ? WAIT : GAP;
               wait_cnt <= WAIT_INIT;
            end
            WAIT: begin
               if (wait_cnt == '0) begin
                  state <= GAP;
                  if (accept) begin
                     burst_cnt <= burst_cnt + 16'd1;
                  end
               end else begin
                  wait_cnt <= wait_cnt - WAIT_W'(1);
               end
            end
            GAP: begin
               if (!enable_i || burst_hit) begin
                  state  <= IDLE;
                  busy_o <= valid_next;
                  // Keeps a finished burst from restarting while enable_i is still high.
                  if (burst_hit) begin
                     burst_hold <= 1'b1;
                  end
               end else if (timer == TIMER_LAST) begin
                  state   <= ISSUE;
                  start_o <= !valid_next;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign evt.evt_valid_o = evt_valid;
   assign evt.x1_o        = coord.x1;
   assign evt.x2_o        = coord.x2;
   assign evt.y1_o        = coord.y1;
   assign evt.y2_o        = coord.y2;

   sat_counter #(.WIDTH(CNT_W)) u_accepted_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (accept),
      .clear   (1'b0),
      .count   (accepted_cnt_o)
   );

   sat_counter #(.WIDTH(CNT_W)) u_rejected_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (reject),
      .clear   (1'b0),
      .count   (rejected_cnt_o)
   );

   sat_counter #(.WIDTH(CNT_W)) u_overrun_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (overrun),
      .clear   (1'b0),
      .count   (overrun_cnt_o)
   );

endmodule

// File: tb/tb_event_scheduler.sv
// Directed bench for event_scheduler: a default build plus a CNT_W=4 build for saturation.
module tb_event_scheduler;

   int checks   = 0;
   int failures = 0;
   int cycle    = 0;
   int exp_acc  = 0;
   int exp_rej  = 0;
   int exp_ovr  = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   logic        reset_n;
   logic        enable;
   logic        gen_valid;
   logic [15:0] burst_len;
   logic [9:0]  x1, x2, y1, y2;
   logic        start, busy, done;
   logic [31:0] acc_cnt, rej_cnt, ovr_cnt;
   logic [39:0] out_coord;

   event_scheduler_if evt ();

   event_scheduler dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .enable_i       (enable),
      .burst_len_i    (burst_len),
      .start_o        (start),
      .gen_valid_i    (gen_valid),
      .x1_i           (x1),
      .x2_i           (x2),
      .y1_i           (y1),
      .y2_i           (y2),
      .evt            (evt),
      .busy_o         (busy),
      .done_o         (done),
      .accepted_cnt_o (acc_cnt),
      .rejected_cnt_o (rej_cnt),
      .overrun_cnt_o  (ovr_cnt)
   );

   assign out_coord = {evt.x1_o, evt.x2_o, evt.y1_o, evt.y2_o};

   logic        enable2;
   logic [15:0] burst_len2;
   logic        start2, busy2, done2;
   logic [3:0]  acc2, rej2, ovr2;

   event_scheduler_if evt2 ();

   event_scheduler #(.PERIOD_CYCLES(8), .RESULT_LATENCY(2), .CNT_W(4)) dut_small (
      .clk            (clk),
      .reset_n        (reset_n),
      .enable_i       (enable2),
      .burst_len_i    (burst_len2),
      .start_o        (start2),
      .gen_valid_i    (gen_valid),
      .x1_i           (x1),
      .x2_i           (x2),
      .y1_i           (y1),
      .y2_i           (y2),
      .evt            (evt2),
      .busy_o         (busy2),
      .done_o         (done2),
      .accepted_cnt_o (acc2),
      .rejected_cnt_o (rej2),
      .overrun_cnt_o  (ovr2)
   );

   function automatic logic [39:0] make_coord(input int i);
      return {10'(i * 7 + 1), 10'(i * 13 + 2), 10'(i * 29 + 3), 10'(1000 - i)};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_start(input int budget, input string tag, output int s);
      bit found = 1'b0;
      s = -1;
      for (int i = 0; i < budget && !found; i++) begin
         step();
         if (start === 1'b1) begin
            found = 1'b1;
            s = cycle;
         end
      end
      checks++;
      if (!found) begin
         failures++;
         $display("[TB] FAIL %s_start_timeout start_o did not rise within %0d cycles", tag, budget);
      end
   endtask

   // Called in the start cycle; drives the generator result at start+2, checks at start+3.
   task automatic finish_slot(input logic gv, input logic [39:0] c, input string tag);
      step();
      checks++;
      if (start !== 1'b0) begin
         failures++;
         $display("[TB] FAIL %s_start_width start_o=%b required 0 one cycle after start", tag, start);
      end
      step();
      gen_valid = gv;
      {x1, x2, y1, y2} = c;
      checks++;
      if (evt.evt_valid_o !== 1'b0) begin
         failures++;
         $display("[TB] FAIL %s_early_valid evt_valid_o=%b required 0 at start+2", tag, evt.evt_valid_o);
      end
      step();
      gen_valid = 1'b0;
      {x1, x2, y1, y2} = ~c;
      if (gv) exp_acc++;
      else exp_rej++;
      checks++;
      if (evt.evt_valid_o !== gv) begin
         failures++;
         $display("[TB] FAIL %s_valid evt_valid_o=%b required %b at start+3", tag, evt.evt_valid_o, gv);
      end
      if (gv) begin
         checks++;
         if (out_coord !== c) begin
            failures++;
            $display("[TB] FAIL %s_coord got %h required %h", tag, out_coord, c);
         end
      end
   endtask

   task automatic end_run(input string tag);
      enable = 1'b0;
      for (int i = 0; i < 300 && busy !== 1'b0; i++) step();
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL %s_idle busy_o=%b required 0 after disable", tag, busy);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      #1;
      checks++;
      if (start !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_ctrl start/busy/done=%b%b%b required 000", start, busy, done);
      end
      checks++;
      if (evt.evt_valid_o !== 1'b0 || out_coord !== 40'd0) begin
         failures++;
         $display("[TB] FAIL reset_event valid=%b coord=%h required 0/0", evt.evt_valid_o, out_coord);
      end
      checks++;
      if (acc_cnt !== 32'd0 || rej_cnt !== 32'd0 || ovr_cnt !== 32'd0) begin
         failures++;
         $display("[TB] FAIL reset_counters acc=%0d rej=%0d ovr=%0d required 0", acc_cnt, rej_cnt, ovr_cnt);
      end
      repeat (3) step();
      reset_n = 1'b1;
      repeat (2) step();
      checks++;
      if (start !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_idle start=%b busy=%b required 0 while disabled", start, busy);
      end
   endtask

   task automatic test_continuous();
      int s, prev;
      evt.evt_ready_i = 1'b1;
      enable = 1'b1;
      wait_start(1, "cont_first", s);
      finish_slot(1'b1, make_coord(0), "cont");
      for (int k = 1; k < 10; k++) begin
         prev = s;
         wait_start(110, "cont", s);
         checks++;
         if (s - prev !== 100) begin
            failures++;
            $display("[TB] FAIL cont_spacing got %0d cycles required 100", s - prev);
         end
         finish_slot(1'b1, make_coord(k), "cont");
      end
      end_run("cont");
      checks++;
      if (acc_cnt !== 32'd10 || rej_cnt !== 32'd0) begin
         failures++;
         $display("[TB] FAIL cont_counts acc=%0d rej=%0d required 10/0", acc_cnt, rej_cnt);
      end
   endtask

   task automatic test_reject();
      int s;
      enable = 1'b1;
      for (int k = 0; k < 8; k++) begin
         wait_start((k == 0) ? 1 : 110, "rej", s);
         finish_slot((k % 2) == 0, make_coord(100 + k), "rej");
      end
      end_run("rej");
      checks++;
      if (acc_cnt !== 32'd14 || rej_cnt !== 32'd4) begin
         failures++;
         $display("[TB] FAIL rej_counts acc=%0d rej=%0d required 14/4", acc_cnt, rej_cnt);
      end
   endtask

   task automatic test_backpressure();
      int s0, s1, bad_start, bad_hold;
      evt.evt_ready_i = 1'b0;
      enable = 1'b1;
      wait_start(1, "bp_first", s0);
      finish_slot(1'b1, make_coord(200), "bp_first");
      bad_start = 0;
      bad_hold  = 0;
      for (int i = 0; i < 250; i++) begin
         if (start !== 1'b0) bad_start++;
         if (evt.evt_valid_o !== 1'b1 || out_coord !== make_coord(200)) bad_hold++;
         step();
      end
      exp_ovr += 2;
      checks++;
      if (bad_start !== 0) begin
         failures++;
         $display("[TB] FAIL bp_no_start saw %0d start cycles required 0", bad_start);
      end
      checks++;
      if (bad_hold !== 0) begin
         failures++;
         $display("[TB] FAIL bp_hold %0d cycles with changed valid/coords required 0", bad_hold);
      end
      checks++;
      if (ovr_cnt !== 32'(exp_ovr)) begin
         failures++;
         $display("[TB] FAIL bp_overruns got %0d required %0d", ovr_cnt, exp_ovr);
      end
      evt.evt_ready_i = 1'b1;
      step();
      checks++;
      if (evt.evt_valid_o !== 1'b0) begin
         failures++;
         $display("[TB] FAIL bp_release evt_valid_o=%b required 0 after handshake", evt.evt_valid_o);
      end
      wait_start(60, "bp_resume", s1);
      checks++;
      if (s1 - s0 !== 300) begin
         failures++;
         $display("[TB] FAIL bp_resume_slot got %0d cycles after first start required 300", s1 - s0);
      end
      finish_slot(1'b1, make_coord(201), "bp_resume");
      end_run("bp");
      checks++;
      if (acc_cnt !== 32'(exp_acc)) begin
         failures++;
         $display("[TB] FAIL bp_accepted got %0d required %0d", acc_cnt, exp_acc);
      end
   endtask

   task automatic test_burst();
      int s, prev, starts, dones;
      evt.evt_ready_i = 1'b1;
      burst_len = 16'd3;
      enable = 1'b1;
      s = 0;
      for (int k = 0; k < 3; k++) begin
         prev = s;
         wait_start((k == 0) ? 1 : 110, "burst", s);
         if (k > 0) begin
            checks++;
            if (s - prev !== 100) begin
               failures++;
               $display("[TB] FAIL burst_spacing got %0d required 100", s - prev);
            end
         end
         finish_slot(1'b1, make_coord(300 + k), "burst");
      end
      checks++;
      if (done !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("[TB] FAIL burst_pre_done done=%b busy=%b required 0/1 at last handshake", done, busy);
      end
      step();
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL burst_done done=%b busy=%b required 1/0 after last handshake", done, busy);
      end
      starts = 0;
      dones  = 0;
      for (int i = 0; i < 250; i++) begin
         step();
         if (start === 1'b1) starts++;
         if (done === 1'b1) dones++;
      end
      checks++;
      if (starts !== 0 || dones !== 0) begin
         failures++;
         $display("[TB] FAIL burst_hold extra starts=%0d dones=%0d required 0/0", starts, dones);
      end
      enable = 1'b0;
      burst_len = 16'd0;
      repeat (2) step();
      checks++;
      if (acc_cnt !== 32'(exp_acc)) begin
         failures++;
         $display("[TB] FAIL burst_accepted got %0d required %0d", acc_cnt, exp_acc);
      end
   endtask

   task automatic test_drain();
      int s, starts;
      evt.evt_ready_i = 1'b0;
      enable = 1'b1;
      wait_start(1, "drain", s);
      step();
      enable = 1'b0;
      step();
      gen_valid = 1'b1;
      {x1, x2, y1, y2} = make_coord(400);
      step();
      gen_valid = 1'b0;
      {x1, x2, y1, y2} = ~make_coord(400);
      exp_acc++;
      checks++;
      if (evt.evt_valid_o !== 1'b1 || out_coord !== make_coord(400)) begin
         failures++;
         $display("[TB] FAIL drain_load valid=%b coord=%h required 1/%h", evt.evt_valid_o, out_coord, make_coord(400));
      end
      repeat (10) step();
      checks++;
      if (busy !== 1'b1 || evt.evt_valid_o !== 1'b1) begin
         failures++;
         $display("[TB] FAIL drain_busy busy=%b valid=%b required 1/1 while event pending", busy, evt.evt_valid_o);
      end
      evt.evt_ready_i = 1'b1;
      step();
      checks++;
      if (busy !== 1'b0 || evt.evt_valid_o !== 1'b0) begin
         failures++;
         $display("[TB] FAIL drain_release busy=%b valid=%b required 0/0", busy, evt.evt_valid_o);
      end
      starts = 0;
      for (int i = 0; i < 150; i++) begin
         step();
         if (start === 1'b1) starts++;
      end
      checks++;
      if (starts !== 0 || acc_cnt !== 32'(exp_acc)) begin
         failures++;
         $display("[TB] FAIL drain_after starts=%0d acc=%0d required 0/%0d", starts, acc_cnt, exp_acc);
      end
   endtask

   task automatic test_saturation();
      int n, starts2_seen;
      evt2.evt_ready_i = 1'b1;
      gen_valid = 1'b1;
      enable2 = 1'b1;
      n = 0;
      starts2_seen = 0;
      for (int i = 0; i < 300 && n < 16; i++) begin
         step();
         if (start2 === 1'b1) starts2_seen++;
         if (evt2.evt_valid_o === 1'b1) begin
            n++;
            if (n == 14) begin
               checks++;
               if (acc2 !== 4'd14) begin
                  failures++;
                  $display("[TB] FAIL sat_14 got %0d required 14", acc2);
               end
            end
            if (n == 15) begin
               checks++;
               if (acc2 !== 4'd15) begin
                  failures++;
                  $display("[TB] FAIL sat_15 got %0d required 15", acc2);
               end
            end
            if (n == 16) begin
               checks++;
               if (acc2 !== 4'd15 || starts2_seen !== 16) begin
                  failures++;
                  $display("[TB] FAIL sat_hold acc=%0d starts=%0d required 15/16", acc2, starts2_seen);
               end
            end
         end
      end
      checks++;
      if (n !== 16 || rej2 !== 4'd0 || ovr2 !== 4'd0 || done2 !== 1'b0 || busy2 !== 1'b1) begin
         failures++;
         $display("[TB] FAIL sat_run events=%0d rej=%0d ovr=%0d done=%b busy=%b required 16/0/0/0/1", n, rej2, ovr2, done2, busy2);
      end
      enable2 = 1'b0;
      gen_valid = 1'b0;
      for (int i = 0; i < 50 && busy2 !== 1'b0; i++) step();
   endtask

   task automatic test_reset_mid();
      int s, loads;
      evt.evt_ready_i = 1'b1;
      enable = 1'b1;
      wait_start(1, "rst_mid", s);
      step();
      gen_valid = 1'b1;
      {x1, x2, y1, y2} = make_coord(500);
      reset_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || start !== 1'b0 || done !== 1'b0 || evt.evt_valid_o !== 1'b0 || out_coord !== 40'd0) begin
         failures++;
         $display("[TB] FAIL rst_mid_async busy=%b start=%b done=%b valid=%b coord=%h required all 0", busy, start, done, evt.evt_valid_o, out_coord);
      end
      checks++;
      if (acc_cnt !== 32'd0 || rej_cnt !== 32'd0 || ovr_cnt !== 32'd0) begin
         failures++;
         $display("[TB] FAIL rst_mid_counters acc=%0d rej=%0d ovr=%0d required 0", acc_cnt, rej_cnt, ovr_cnt);
      end
      exp_acc = 0;
      exp_rej = 0;
      exp_ovr = 0;
      loads = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (evt.evt_valid_o !== 1'b0) loads++;
      end
      gen_valid = 1'b0;
      reset_n = 1'b1;
      step();
      checks++;
      if (start !== 1'b1 || loads !== 0) begin
         failures++;
         $display("[TB] FAIL rst_mid_restart start=%b stray_valid=%0d required 1/0", start, loads);
      end
      finish_slot(1'b0, make_coord(501), "rst_mid");
      end_run("rst_mid");
      checks++;
      if (acc_cnt !== 32'd0 || rej_cnt !== 32'd1) begin
         failures++;
         $display("[TB] FAIL rst_mid_counts acc=%0d rej=%0d required 0/1", acc_cnt, rej_cnt);
      end
   endtask

   initial begin
      reset_n          = 1'b1;
      enable           = 1'b0;
      enable2          = 1'b0;
      gen_valid        = 1'b0;
      burst_len        = 16'd0;
      burst_len2       = 16'd0;
      {x1, x2, y1, y2} = 40'd0;
      evt.evt_ready_i  = 1'b1;
      evt2.evt_ready_i = 1'b1;
      #2;
      test_reset();
      test_continuous();
      test_reject();
      test_backpressure();
      test_burst();
      test_drain();
      test_saturation();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
